// File: rtl/arm_serial_arbiter_if.sv
// Requester/buffer-side bundle of the serial arbiter: request vectors in,
// handshake pulses and registered buffer controls out.
interface arm_serial_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned A_W  = 7,
  parameter int unsigned D_W  = 8
);
  localparam int unsigned ID_W = $clog2(NREQ);

  logic [NREQ-1:0]     req;
  logic [NREQ*A_W-1:0] req_A;
  logic [NREQ*D_W-1:0] req_D;
  logic [NREQ-1:0]     ack;
  logic [NREQ-1:0]     done;
  logic                Go;
  logic [A_W-1:0]      A;
  logic [D_W-1:0]      D;
  logic                busy;
  logic [ID_W-1:0]     grant_id;

  // Requester side: drives requests, observes handshakes.
  modport master (
    output req, req_A, req_D,
    input  ack, done, Go, A, D, busy, grant_id
  );

  // Arbiter side.
  modport slave (
    input  req, req_A, req_D,
    output ack, done, Go, A, D, busy, grant_id
  );
endinterface

// File: rtl/arm_serial_arbiter.sv
// Round-robin arbiter that shares one serial output buffer between NREQ
// requesters, launching one fixed-length frame per grant.
module arm_serial_arbiter #(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned A_W          = 7,
  parameter int unsigned D_W          = 8,
  parameter int unsigned FRAME_CYCLES = 25
) (
  input  logic                  clk_in,
  input  logic                  reset_n,
  arm_serial_arbiter_if.slave   bus
);
  localparam int unsigned ID_W  = $clog2(NREQ);
  localparam int unsigned CNT_W = $clog2(FRAME_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_CYCLES - 2);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0] gid_q, gid_d;
  logic [A_W-1:0]  a_q, a_d;
  logic [D_W-1:0]  d_q, d_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            go_q, go_d;
  logic            busy_q, busy_d;

  logic            found;
  logic [ID_W-1:0] g;
  int unsigned     idx;

  // Rotating priority search: first set request at or above ptr, wrapping.
  always_comb begin
    found = 1'b0;
    g     = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr_q) + k) % NREQ;
      if (!found && bus.req[ID_W'(idx)]) begin
        found = 1'b1;
        g     = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gid_q   <= '0;
      a_q     <= '0;
      d_q     <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      go_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gid_q   <= gid_d;
      a_q     <= a_d;
      d_q     <= d_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      go_q    <= go_d;
      busy_q  <= busy_d;
    end
  end

  // Pulses are computed one cycle early so they appear registered in the
  // state they belong to (Go/ack in LAUNCH, done in the first IDLE cycle).
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gid_d   = gid_q;
    a_d     = a_q;
    d_d     = d_q;
    ack_d   = '0;
    done_d  = '0;
    go_d    = 1'b0;
    busy_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          a_d     = bus.req_A[32'(g)*A_W +: A_W];
          d_d     = bus.req_D[32'(g)*D_W +: D_W];
          gid_d   = g;
          ptr_d   = ID_W'((32'(g) + 1) % NREQ);
          ack_d   = NREQ'(1) << g;
          go_d    = 1'b1;
          busy_d  = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_d   = CNT_LOAD;
        busy_d  = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          done_d  = NREQ'(1) << gid_q;
          state_d = IDLE;
        end else begin
          cnt_d  = cnt_q - CNT_W'(1);
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ack      = ack_q;
  assign bus.done     = done_q;
  assign bus.Go       = go_q;
  assign bus.A        = a_q;
  assign bus.D        = d_q;
  assign bus.busy     = busy_q;
  assign bus.grant_id = gid_q;
endmodule

// File: tb/tb_arm_serial_arbiter.sv
// Directed bench for arm_serial_arbiter: reset, single frame, round-robin,
// pointer wrap, late/stale requests and reset mid-frame.
module tb_arm_serial_arbiter;
  localparam int unsigned NREQ = 4;
  localparam int unsigned A_W  = 7;
  localparam int unsigned D_W  = 8;
  localparam int unsigned FC   = 25;

  logic clk_in = 1'b0;
  logic reset_n;
  always #5 clk_in = ~clk_in;

  arm_serial_arbiter_if #(.NREQ(NREQ), .A_W(A_W), .D_W(D_W)) bus ();

  arm_serial_arbiter #(.NREQ(NREQ), .A_W(A_W), .D_W(D_W), .FRAME_CYCLES(FC)) dut (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Pulse-shape watchdog sampled mid-cycle.
  logic viol      = 1'b0;
  logic prev_go   = 1'b0;
  logic prev_ack  = 1'b0;
  logic prev_done = 1'b0;
  always @(negedge clk_in) begin
    if (reset_n === 1'b1) begin
      if (bus.Go && prev_go) viol = 1'b1;
      if ((|bus.ack) && prev_ack) viol = 1'b1;
      if ((|bus.done) && prev_done) viol = 1'b1;
      if ((bus.ack & bus.done) != '0) viol = 1'b1;
      if ((|bus.done) && bus.Go) viol = 1'b1;
    end
    prev_go   = bus.Go;
    prev_ack  = |bus.ack;
    prev_done = |bus.done;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_go(input int budget, output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!bus.Go && n < budget);
    check("go_seen", 32'(bus.Go), 32'd1);
  endtask

  task automatic check_grant(input string tag, input int gexp,
                             input logic [A_W-1:0] aexp, input logic [D_W-1:0] dexp);
    check({tag, "_gid"}, 32'(bus.grant_id), 32'(gexp));
    check({tag, "_ack"}, 32'(bus.ack), 32'(4'b0001 << gexp));
    check({tag, "_A"}, 32'(bus.A), 32'(aexp));
    check({tag, "_D"}, 32'(bus.D), 32'(dexp));
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
  endtask

  initial begin
    int n;
    logic acc_busy, acc_go;
    logic [NREQ-1:0] acc_ack, acc_done;

    reset_n     = 1'b0;
    bus.req     = '0;
    bus.req_A   = '0;
    bus.req_D   = '0;
    #1;
    step(2);
    reset_n = 1'b1;
    check("rst_go", 32'(bus.Go), 0);
    check("rst_ack", 32'(bus.ack), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_A", 32'(bus.A), 0);
    check("rst_D", 32'(bus.D), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_gid", 32'(bus.grant_id), 0);
    acc_busy = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      acc_busy |= bus.busy;
    end
    check("idle_busy", 32'(acc_busy), 0);

    // Single request from requester 0.
    bus.req         = 4'b0001;
    bus.req_A[6:0]  = 7'b1000001;
    bus.req_D[7:0]  = 8'b10000001;
    step(1);
    check("single_go", 32'(bus.Go), 1);
    check_grant("single", 0, 7'b1000001, 8'b10000001);
    bus.req = '0;
    step(1);
    check("single_go_drop", 32'(bus.Go), 0);
    check("single_ack_drop", 32'(bus.ack), 0);
    step(23);
    check("single_busy25", 32'(bus.busy), 1);
    check("single_done_early", 32'(bus.done), 0);
    step(1);
    check("single_done", 32'(bus.done), 32'h1);
    check("single_busy_end", 32'(bus.busy), 0);
    step(1);
    check("single_done_drop", 32'(bus.done), 0);

    // Restart pointer, then all requesters hold req high.
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_A[i*A_W +: A_W] = 7'(8'h10 + i);
      bus.req_D[i*D_W +: D_W] = 8'(8'hA0 + i);
    end
    bus.req = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      wait_go(40, n);
      check("rr_spacing", 32'(n), (f == 0) ? 32'd1 : 32'd26);
      check_grant("rr", f % 4, 7'(8'h10 + (f % 4)), 8'(8'hA0 + (f % 4)));
    end

    // Pointer wrap: grant 3, then req 0101 gives 0 before 2.
    bus.req = 4'b1000;
    wait_go(40, n);
    check("wrap3_spacing", 32'(n), 32'd26);
    check_grant("wrap3", 3, 7'h13, 8'hA3);
    bus.req = 4'b0101;
    wait_go(40, n);
    check("wrap0_spacing", 32'(n), 32'd26);
    check_grant("wrap0", 0, 7'h10, 8'hA0);
    bus.req = 4'b0100;
    wait_go(40, n);
    check("wrap2_spacing", 32'(n), 32'd26);
    check_grant("wrap2", 2, 7'h12, 8'hA2);
    bus.req = '0;

    // Late request pulsed during WAIT is lost.
    step(5);
    bus.req = 4'b0010;
    step(3);
    bus.req = '0;
    acc_ack  = '0;
    acc_done = '0;
    acc_go   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      acc_ack  |= bus.ack;
      acc_done |= bus.done;
      acc_go   |= bus.Go;
    end
    check("late_ack", 32'(acc_ack), 0);
    check("late_go", 32'(acc_go), 0);
    check("late_done", 32'(acc_done), 32'h4);

    // Stale request: req[2] kept high yields a back-to-back second frame.
    bus.req = 4'b0100;
    wait_go(40, n);
    check("stale1_lat", 32'(n), 32'd1);
    check_grant("stale1", 2, 7'h12, 8'hA2);
    step(25);
    check("stale_done", 32'(bus.done), 32'h4);
    wait_go(40, n);
    check("stale2_lat", 32'(n), 32'd1);
    check_grant("stale2", 2, 7'h12, 8'hA2);
    bus.req = '0;

    // Reset at frame cycle 10 clears outputs without a clock edge.
    step(9);
    check("mid_busy_pre", 32'(bus.busy), 1);
    reset_n = 1'b0;
    #1;
    check("mid_busy", 32'(bus.busy), 0);
    check("mid_A", 32'(bus.A), 0);
    check("mid_D", 32'(bus.D), 0);
    check("mid_gid", 32'(bus.grant_id), 0);
    check("mid_go", 32'(bus.Go), 0);
    step(2);
    reset_n  = 1'b1;
    acc_done = '0;
    acc_busy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      acc_done |= bus.done;
      acc_busy |= bus.busy;
    end
    check("abort_done", 32'(acc_done), 0);
    check("abort_busy", 32'(acc_busy), 0);
    bus.req = 4'b0010;
    wait_go(40, n);
    check("post_lat", 32'(n), 32'd1);
    check_grant("post", 1, 7'h11, 8'hA1);
    bus.req = '0;
    step(25);
    check("post_done", 32'(bus.done), 32'h2);
    bus.req = 4'b1001;
    wait_go(40, n);
    check("post_ptr_lat", 32'(n), 32'd1);
    check_grant("post_ptr", 3, 7'h13, 8'hA3);
    bus.req = '0;
    step(25);
    check("post_ptr_done", 32'(bus.done), 32'h8);

    check("pulse_shape", 32'(viol), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
